uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_pkg.sv | 16 +
 rtl/pulse_generator.sv | 35 +++
 rtl/uart_tx_sequencer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity-mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/pulse_generator.sv
// Free-running interval timer: emits a one-cycle registered pulse every INTERVAL clocks after reset release.
module pulse_generator #(
  parameter int INTERVAL = 16
) (
  input  logic clk,
  input  logic rst,
  output logic pulse
);

  localparam int CNT_W = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(INTERVAL - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Pulse is registered one count early so it lines up with the last count of each interval.
  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    pulse_d = (cnt_q == CNT_PRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmitter: accepts a word on valid/ready and serialises start, data (LSB first),
// optional parity and stop bits, each held for CLKS_PER_BIT clocks.
module uart_tx_sequencer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bitCnt_q, bitCnt_d;
  logic                 stopCnt_q, stopCnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 tickRst;

  // Holding the timer in reset while idle phase-aligns every start bit to its acceptance edge.
  assign tickRst = rst || (state_q == ST_IDLE);

  pulse_generator #(
    .INTERVAL(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (tickRst),
    .pulse(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are computed one cycle ahead so tx/ready/busy come straight from flops.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (valid && ready_q) begin
          state_d  = ST_START;
          shift_d  = data;
          parity_d = (^data) ^ (PARITY == PARITY_ODD);
          tx_d     = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d  = ST_DATA;
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
          bitCnt_d = '0;
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bitCnt_q == BIT_LAST) begin
            bitCnt_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d   = ST_STOP;
              tx_d      = 1'b1;
              stopCnt_d = 1'b0;
            end
          end else begin
            bitCnt_d = bitCnt_q + BC_W'(1);
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          stopCnt_d = 1'b0;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (stopCnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stopCnt_d = stopCnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: four instances (no parity, even, odd, two stop bits)
// at 4 clocks per bit, checked cycle by cycle against a small frame model.
module tb_uart_tx_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] dataIn   [4];
  logic       validIn  [4];
  logic       readyOut [4];
  logic       txOut    [4];
  logic       busyOut  [4];

  int numCompared;
  int numMismatched;

  uart_tx_sequencer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutNone (
    .clk(clk), .rst(rst), .data(dataIn[0]), .valid(validIn[0]),
    .ready(readyOut[0]), .tx(txOut[0]), .busy(busyOut[0]));

  uart_tx_sequencer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutEven (
    .clk(clk), .rst(rst), .data(dataIn[1]), .valid(validIn[1]),
    .ready(readyOut[1]), .tx(txOut[1]), .busy(busyOut[1]));

  uart_tx_sequencer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutOdd (
    .clk(clk), .rst(rst), .data(dataIn[2]), .valid(validIn[2]),
    .ready(readyOut[2]), .tx(txOut[2]), .busy(busyOut[2]));

  uart_tx_sequencer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dutStop2 (
    .clk(clk), .rst(rst), .data(dataIn[3]), .valid(validIn[3]),
    .ready(readyOut[3]), .tx(txOut[3]), .busy(busyOut[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge, where outputs are sampled and inputs driven.
  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  // Expected tx in cycle n (1-based) of a frame at 4 clocks per bit: start, 8 data LSB first, optional parity, then stop/idle high.
  function automatic logic frameBit(input logic [7:0] d, input logic hasPar, input logic parBit, input int n);
    int slot;
    slot = (n - 1) / 4;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (hasPar && slot == 9) return parBit;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      validIn[i] = 1'b0;
      dataIn[i]  = 8'h00;
    end
    stepCycle();
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      numCompared++;
      if (txOut[i] !== 1'b1 || readyOut[i] !== 1'b0 || busyOut[i] !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL reset_outputs dut%0d: tx/ready/busy=%b%b%b expected 100", i, txOut[i], readyOut[i], busyOut[i]);
      end
    end
    rst = 1'b0;
    numCompared++;
    if (readyOut[0] !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL reset_release_early: ready=%b expected 0", readyOut[0]);
    end
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      numCompared++;
      if (readyOut[i] !== 1'b1 || txOut[i] !== 1'b1 || busyOut[i] !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL reset_release dut%0d: tx/ready/busy=%b%b%b expected 110", i, txOut[i], readyOut[i], busyOut[i]);
      end
    end
  endtask

  task automatic test_single_frame;
    logic expTx;
    numCompared++;
    if (readyOut[0] !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL t1_ready_before: ready=%b expected 1", readyOut[0]);
    end
    dataIn[0]  = 8'hA5;
    validIn[0] = 1'b1;
    stepCycle();
    validIn[0] = 1'b0;
    dataIn[0]  = 8'h00;
    for (int n = 1; n <= 40; n++) begin
      expTx = frameBit(8'hA5, 1'b0, 1'b0, n);
      numCompared++;
      if (txOut[0] !== expTx || busyOut[0] !== 1'b1 || readyOut[0] !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL t1_frame cycle %0d: tx/busy/ready=%b%b%b expected %b10", n, txOut[0], busyOut[0], readyOut[0], expTx);
      end
      stepCycle();
    end
    numCompared++;
    if (readyOut[0] !== 1'b1 || busyOut[0] !== 1'b0 || txOut[0] !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL t1_end cycle 41: ready/busy/tx=%b%b%b expected 101", readyOut[0], busyOut[0], txOut[0]);
    end
  endtask

  task automatic test_parity;
    logic expTx;
    logic parBit;
    int   idx;
    for (int k = 0; k < 2; k++) begin
      idx    = k + 1;
      // 0xA5 has four ones: even parity bit 0, odd parity bit 1.
      parBit = (k == 0) ? 1'b0 : 1'b1;
      dataIn[idx]  = 8'hA5;
      validIn[idx] = 1'b1;
      stepCycle();
      validIn[idx] = 1'b0;
      for (int n = 1; n <= 44; n++) begin
        expTx = frameBit(8'hA5, 1'b1, parBit, n);
        numCompared++;
        if (txOut[idx] !== expTx || readyOut[idx] !== 1'b0) begin
          numMismatched++;
          $display("[TB] FAIL t2_parity dut%0d cycle %0d: tx/ready=%b%b expected %b0", idx, n, txOut[idx], readyOut[idx], expTx);
        end
        stepCycle();
      end
      numCompared++;
      if (readyOut[idx] !== 1'b1 || busyOut[idx] !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL t2_end dut%0d cycle 45: ready/busy=%b%b expected 10", idx, readyOut[idx], busyOut[idx]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic expTx;
    dataIn[3]  = 8'h00;
    validIn[3] = 1'b1;
    stepCycle();
    dataIn[3] = 8'hFF;
    for (int n = 1; n <= 44; n++) begin
      expTx = frameBit(8'h00, 1'b0, 1'b0, n);
      numCompared++;
      if (txOut[3] !== expTx || readyOut[3] !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL t3_frame0 cycle %0d: tx/ready=%b%b expected %b0", n, txOut[3], readyOut[3], expTx);
      end
      stepCycle();
    end
    numCompared++;
    if (txOut[3] !== 1'b1 || readyOut[3] !== 1'b1 || busyOut[3] !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL t3_gap cycle 45: tx/ready/busy=%b%b%b expected 110", txOut[3], readyOut[3], busyOut[3]);
    end
    stepCycle();
    validIn[3] = 1'b0;
    for (int n = 1; n <= 44; n++) begin
      expTx = frameBit(8'hFF, 1'b0, 1'b0, n);
      numCompared++;
      if (txOut[3] !== expTx || readyOut[3] !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL t3_frame1 cycle %0d: tx/ready=%b%b expected %b0", n + 45, txOut[3], readyOut[3], expTx);
      end
      stepCycle();
    end
    numCompared++;
    if (readyOut[3] !== 1'b1 || busyOut[3] !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL t3_end cycle 90: ready/busy=%b%b expected 10", readyOut[3], busyOut[3]);
    end
    stepCycle();
    numCompared++;
    if (busyOut[3] !== 1'b0 || txOut[3] !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL t3_no_extra cycle 91: busy/tx=%b%b expected 01", busyOut[3], txOut[3]);
    end
  endtask

  task automatic test_ignore_while_busy;
    logic expTx;
    dataIn[0]  = 8'h3C;
    validIn[0] = 1'b1;
    stepCycle();
    for (int n = 1; n <= 40; n++) begin
      expTx = frameBit(8'h3C, 1'b0, 1'b0, n);
      numCompared++;
      if (txOut[0] !== expTx) begin
        numMismatched++;
        $display("[TB] FAIL t4_frame cycle %0d: tx=%b expected %b", n, txOut[0], expTx);
      end
      dataIn[0]  = 8'(n * 37);
      validIn[0] = (n < 40) ? n[0] : 1'b0;
      stepCycle();
    end
    for (int n = 41; n <= 48; n++) begin
      numCompared++;
      if (txOut[0] !== 1'b1 || busyOut[0] !== 1'b0 || readyOut[0] !== 1'b1) begin
        numMismatched++;
        $display("[TB] FAIL t4_idle cycle %0d: tx/busy/ready=%b%b%b expected 101", n, txOut[0], busyOut[0], readyOut[0]);
      end
      stepCycle();
    end
  endtask

  task automatic test_reset_midframe;
    logic expTx;
    dataIn[0]  = 8'h96;
    validIn[0] = 1'b1;
    stepCycle();
    validIn[0] = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      expTx = frameBit(8'h96, 1'b0, 1'b0, n);
      numCompared++;
      if (txOut[0] !== expTx) begin
        numMismatched++;
        $display("[TB] FAIL t5_pre cycle %0d: tx=%b expected %b", n, txOut[0], expTx);
      end
      if (n < 18) stepCycle();
    end
    #2;
    rst = 1'b1;
    #1;
    numCompared++;
    if (txOut[0] !== 1'b1 || readyOut[0] !== 1'b0 || busyOut[0] !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL t5_async: tx/ready/busy=%b%b%b expected 100", txOut[0], readyOut[0], busyOut[0]);
    end
    stepCycle();
    rst = 1'b0;
    numCompared++;
    if (readyOut[0] !== 1'b0 || txOut[0] !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL t5_held: ready/tx=%b%b expected 01", readyOut[0], txOut[0]);
    end
    stepCycle();
    numCompared++;
    if (readyOut[0] !== 1'b1 || busyOut[0] !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL t5_release: ready/busy=%b%b expected 10", readyOut[0], busyOut[0]);
    end
    dataIn[0]  = 8'hC3;
    validIn[0] = 1'b1;
    stepCycle();
    validIn[0] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      expTx = frameBit(8'hC3, 1'b0, 1'b0, n);
      numCompared++;
      if (txOut[0] !== expTx || readyOut[0] !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL t5_frame cycle %0d: tx/ready=%b%b expected %b0", n, txOut[0], readyOut[0], expTx);
      end
      stepCycle();
    end
    numCompared++;
    if (readyOut[0] !== 1'b1 || txOut[0] !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL t5_end cycle 41: ready/tx=%b%b expected 11", readyOut[0], txOut[0]);
    end
  endtask

  // Tests run in sequence; each starts with all instances idle.
  initial begin
    numCompared   = 0;
    numMismatched = 0;
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
